// File: rtl/instr_issue_ctrl.sv
// Buffers instruction words in a small FIFO, decodes them and issues registered datapath controls.
// Controls appear the cycle after a word is popped; instr_ready drops when the FIFO is full or after HALT.
module instr_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  read_reg_num1,
  output logic [4:0]  read_reg_num2,
  output logic [4:0]  write_reg,
  output logic [2:0]  alu_control,
  output logic [15:0] immediate,
  output logic        imm_ctrl,
  output logic        lw_ctrl,
  output logic        sw_ctrl,
  output logic        write_enable,
  output logic        mode,
  output logic        busy,
  output logic        halted,
  output logic [7:0]  illegal_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, MEM, HALT} state_t;

  typedef struct packed {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [2:0]  alu;
    logic [15:0] imm;
    logic        imm_sel;
    logic        lw;
    logic        sw;
  } ctrl_t;

  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push, pop, flush;
  logic [31:0] head;

  state_t      state, state_nxt;
  ctrl_t       ctrl_q, ctrl_nxt, dec;
  logic [RW-1:0] remain, remain_nxt;
  logic        we_nxt, mode_nxt, halted_nxt, ill_inc, issue;
  logic [2:0]  cls;
  logic        is_rw, is_mem, is_lw, is_halt, is_ill;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign instr_ready = !fifo_full && !halted;
  assign push        = instr_valid && instr_ready;
  assign head        = fifo_mem[rd_ptr[AW-1:0]];
  assign busy        = !fifo_empty || (state == ISSUE) || (state == MEM);

  assign read_reg_num1 = ctrl_q.r1;
  assign read_reg_num2 = ctrl_q.r2;
  assign write_reg     = ctrl_q.wr;
  assign alu_control   = ctrl_q.alu;
  assign immediate     = ctrl_q.imm;
  assign imm_ctrl      = ctrl_q.imm_sel;
  assign lw_ctrl       = ctrl_q.lw;
  assign sw_ctrl       = ctrl_q.sw;

  assign cls     = head[31:29];
  assign is_rw   = (cls == 3'b000) || (cls == 3'b001);
  assign is_mem  = (cls[2:1] == 2'b01);
  assign is_lw   = (cls == 3'b010);
  assign is_halt = (cls == 3'b111);
  assign is_ill  = (cls[2:1] == 2'b10);

  always_comb begin
    dec = '0;
    case (cls)
      3'b000: begin
        dec.r1  = head[25:21];
        dec.r2  = head[20:16];
        dec.wr  = head[15:11];
        dec.alu = head[2:0];
      end
      3'b001: begin
        dec.imm_sel = 1'b1;
        dec.imm     = head[15:0];
        dec.r2      = head[20:16];
        dec.wr      = head[15:11];
        dec.alu     = head[28:26];
      end
      3'b010, 3'b011: begin
        dec.lw  = (cls == 3'b010);
        dec.sw  = (cls == 3'b011);
        dec.r1  = head[25:21];
        dec.r2  = head[20:16];
        dec.alu = head[28:26];
      end
      default: dec = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    ctrl_nxt   = ctrl_q;
    remain_nxt = remain;
    we_nxt     = 1'b0;
    mode_nxt   = 1'b0;
    halted_nxt = halted;
    issue      = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    ill_inc    = 1'b0;
    case (state)
      IDLE: begin
        ctrl_nxt = '0;
        issue    = !fifo_empty;
      end
      ISSUE, MEM: begin
        if (remain != '0) begin
          // Load/store keeps its controls; LW writes back in its last cycle only.
          state_nxt  = MEM;
          remain_nxt = remain - RW'(1);
          we_nxt     = ctrl_q.lw && (remain == RW'(1));
          mode_nxt   = we_nxt;
        end else if (!fifo_empty) begin
          issue = 1'b1;
        end else begin
          state_nxt = IDLE;
          ctrl_nxt  = '0;
        end
      end
      default: ctrl_nxt = '0;
    endcase

    if (issue) begin
      pop = 1'b1;
      if (is_halt) begin
        state_nxt  = HALT;
        halted_nxt = 1'b1;
        ctrl_nxt   = '0;
        flush      = 1'b1;
      end else begin
        state_nxt  = ISSUE;
        ctrl_nxt   = dec;
        remain_nxt = is_mem ? RW'(MEM_LAT - 1) : '0;
        we_nxt     = is_rw || (is_lw && (MEM_LAT == 1));
        mode_nxt   = we_nxt;
        ill_inc    = is_ill;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q        <= '0;
      remain        <= '0;
      write_enable  <= 1'b0;
      mode          <= 1'b0;
      halted        <= 1'b0;
      illegal_count <= 8'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      ctrl_q       <= ctrl_nxt;
      remain       <= remain_nxt;
      write_enable <= we_nxt;
      mode         <= mode_nxt;
      halted       <= halted_nxt;
      if (ill_inc && (illegal_count != 8'hFF))
        illegal_count <= illegal_count + 8'd1;
      // A word accepted in the HALT cycle is discarded along with the rest.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= instr;
  end
endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Self-checking bench: decode table, directed multi-cycle sequences, and random traffic against a queue model.
module tb_instr_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
  logic [2:0]  alu_control;
  logic [15:0] immediate;
  logic        imm_ctrl, lw_ctrl, sw_ctrl, write_enable, mode, busy, halted;
  logic [7:0]  illegal_count;

  always #5 clock = ~clock;

  instr_issue_ctrl #(.FIFO_DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg(write_reg), .alu_control(alu_control), .immediate(immediate),
    .imm_ctrl(imm_ctrl), .lw_ctrl(lw_ctrl), .sw_ctrl(sw_ctrl), .write_enable(write_enable),
    .mode(mode), .busy(busy), .halted(halted), .illegal_count(illegal_count)
  );

  typedef struct packed {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [2:0]  alu;
    logic [15:0] imm;
    logic        ic;
    logic        lw;
    logic        sw;
    logic        we;
    logic        md;
  } obs_t;

  typedef struct {
    logic [31:0] w;
    obs_t        e;
    string       name;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  logic [31:0] wq[$];
  obs_t oq[$];
  bit   m_halted;
  int   m_ill;
  int   we_pulses;
  bit   last_acc;
  vec_t tbl[9];

  function automatic obs_t mk(int r1, int r2, int wr, int alu, int imm, bit ic, bit lw, bit sw, bit we);
    obs_t o;
    o.r1 = 5'(r1); o.r2 = 5'(r2); o.wr = 5'(wr); o.alu = 3'(alu); o.imm = 16'(imm);
    o.ic = ic; o.lw = lw; o.sw = sw; o.we = we; o.md = we;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.r1 = read_reg_num1; o.r2 = read_reg_num2; o.wr = write_reg; o.alu = alu_control;
    o.imm = immediate; o.ic = imm_ctrl; o.lw = lw_ctrl; o.sw = sw_ctrl;
    o.we = write_enable; o.md = mode;
    return o;
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    wq.delete(); oq.delete(); m_halted = 0; m_ill = 0;
  endfunction

  // Expected per-cycle controls of one issued word, straight from the class table.
  function automatic void expand(logic [31:0] w);
    obs_t o;
    logic [2:0] c;
    c = w[31:29];
    o = '0;
    case (c)
      3'b000: begin
        o.r1 = w[25:21]; o.r2 = w[20:16]; o.wr = w[15:11]; o.alu = w[2:0];
        o.we = 1; o.md = 1; oq.push_back(o);
      end
      3'b001: begin
        o.ic = 1; o.imm = w[15:0]; o.r2 = w[20:16]; o.wr = w[15:11]; o.alu = w[28:26];
        o.we = 1; o.md = 1; oq.push_back(o);
      end
      3'b010, 3'b011: begin
        o.r1 = w[25:21]; o.r2 = w[20:16]; o.alu = w[28:26];
        o.lw = (c == 3'b010); o.sw = (c == 3'b011);
        for (int i = 0; i < LAT; i++) begin
          obs_t t;
          t = o;
          if (o.lw && i == LAT - 1) begin t.we = 1; t.md = 1; end
          oq.push_back(t);
        end
      end
      3'b100, 3'b101: begin
        oq.push_back(o);
        if (m_ill < 255) m_ill++;
      end
      default: oq.push_back(o);
    endcase
  endfunction

  task automatic step();
    bit acc, halt_now;
    logic [31:0] w, x;
    obs_t exp;
    acc = instr_valid && (wq.size() < DEPTH) && !m_halted;
    w = instr;
    @(posedge clock);
    #1;
    if (oq.size() > 0) void'(oq.pop_front());
    halt_now = 0;
    if (oq.size() == 0 && !m_halted && wq.size() > 0) begin
      x = wq.pop_front();
      if (x[31:29] == 3'b111) begin
        m_halted = 1; wq.delete(); halt_now = 1;
      end else begin
        expand(x);
      end
    end
    if (acc && !halt_now) wq.push_back(w);
    last_acc = acc;
    if (write_enable) we_pulses++;
    if (oq.size() > 0) exp = oq[0];
    else exp = '0;
    check_obs("cycle_ctrl", dut_obs(), exp);
    check_int("cycle_status", {instr_ready, busy, halted, illegal_count},
              {((wq.size() < DEPTH) && !m_halted), (wq.size() > 0 || oq.size() > 0), m_halted, 8'(m_ill)});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || oq.size() > 0 || wq.size() > 0) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic push_word(logic [31:0] w);
    int n;
    n = 0;
    instr = w;
    instr_valid = 1;
    last_acc = 0;
    while (!last_acc && n < 50) begin
      step();
      n++;
    end
    instr_valid = 0;
    checks++;
    if (!last_acc) begin
      failures++;
      $display("FAIL accept_timeout actual=not_taken required=taken word=%h", w);
    end
  endtask

  task automatic apply_reset();
    reset = 1;
    instr_valid = 0;
    @(posedge clock);
    #1;
    reset = 0;
    m_reset();
    we_pulses = 0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [2:0] c;
    case ($urandom_range(0, 6))
      0: c = 3'b000;
      1: c = 3'b001;
      2: c = 3'b010;
      3: c = 3'b011;
      4: c = 3'b110;
      5: c = 3'b100;
      default: c = 3'b101;
    endcase
    w = $urandom;
    w[31:29] = c;
    return w;
  endfunction

  initial begin
    obs_t lw2;
    int j, n, n_acc;
    bit saw_low;

    tbl[0] = '{32'h0022_1802, mk(1, 2, 3, 2, 0, 0, 0, 0, 1), "r_type_a"};
    tbl[1] = '{32'h0043_2005, mk(2, 3, 4, 5, 0, 0, 0, 0, 1), "r_type_b"};
    tbl[2] = '{32'h2420_10FF, mk(0, 0, 2, 1, 16'h10FF, 1, 0, 0, 1), "i_type"};
    tbl[3] = '{32'h40A6_0000, mk(5, 6, 0, 0, 0, 0, 1, 0, 0), "lw_first"};
    tbl[4] = '{32'h6CE8_ABCD, mk(7, 8, 0, 3, 0, 0, 0, 1, 0), "sw_first"};
    tbl[5] = '{32'hDFFF_FFFF, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "nop"};
    tbl[6] = '{32'h9FFF_FFFF, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "illegal_100"};
    tbl[7] = '{32'hA000_0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "illegal_101"};
    tbl[8] = '{32'h1FE0_8801, mk(31, 0, 17, 1, 0, 0, 0, 0, 1), "r_alu_override"};

    // Reset state.
    m_reset();
    we_pulses = 0;
    #12;
    check_obs("reset_ctrl", dut_obs(), '0);
    check_int("reset_status", {busy, halted, illegal_count}, 0);
    reset = 0;
    #1;
    check_int("ready_after_reset", instr_ready, 1);

    // Decode table: one word into an idle block, controls checked the cycle after acceptance.
    foreach (tbl[i]) begin
      wait_idle();
      instr = tbl[i].w;
      instr_valid = 1;
      step();
      instr_valid = 0;
      check_int({tbl[i].name, "_accept"}, last_acc, 1);
      step();
      check_obs(tbl[i].name, dut_obs(), tbl[i].e);
    end
    wait_idle();
    check_int("table_illegal_count", illegal_count, 2);

    // Back-to-back R-types.
    instr_valid = 1;
    instr = tbl[0].w; step();
    instr = tbl[1].w; step();
    instr_valid = 0;
    check_obs("rr_cycle1", dut_obs(), tbl[0].e);
    step();
    check_obs("rr_cycle2", dut_obs(), tbl[1].e);
    wait_idle();

    // LW holds for LAT cycles, write strobe in the last, then a queued R-type.
    lw2 = tbl[3].e; lw2.we = 1; lw2.md = 1;
    instr_valid = 1;
    instr = tbl[3].w; step();
    instr = tbl[0].w; step();
    instr_valid = 0;
    check_obs("lw_cycle1", dut_obs(), tbl[3].e);
    step();
    check_obs("lw_cycle2", dut_obs(), lw2);
    step();
    check_obs("lw_then_r", dut_obs(), tbl[0].e);
    wait_idle();

    // Stream of loads with valid held: FIFO fills, source holds, nothing lost.
    we_pulses = 0; n_acc = 0; saw_low = 0; j = 0;
    instr_valid = 1;
    for (int c = 0; c < 24; c++) begin
      instr = {3'b010, 3'(j), 5'(j), 5'(j + 1), 16'(j)};
      step();
      if (last_acc) begin n_acc++; j++; end
      if (!instr_ready) saw_low = 1;
    end
    instr_valid = 0;
    wait_idle();
    check_int("full_ready_low", saw_low, 1);
    check_int("full_no_loss", we_pulses, n_acc);

    // Illegal words then HALT: following R-type never issues.
    apply_reset();
    push_word(32'h8000_0001);
    push_word(32'h8000_0002);
    push_word(32'h8000_0003);
    push_word(32'hE000_0000);
    push_word(tbl[0].w);
    for (int c = 0; c < 4; c++) step();
    instr = tbl[0].w;
    instr_valid = 1;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (last_acc) n++;
    end
    instr_valid = 0;
    check_int("halt_illegal_count", illegal_count, 3);
    check_int("halt_no_write", we_pulses, 0);
    check_int("halt_flag", halted, 1);
    check_int("halt_ready", instr_ready, 0);
    check_int("halt_no_accept", n, 0);

    // Asynchronous reset during a load, with an R-type queued behind it.
    apply_reset();
    push_word(tbl[3].w);
    instr = tbl[0].w;
    instr_valid = 1;
    step();
    instr_valid = 0;
    check_int("pre_reset_lw", lw_ctrl, 1);
    #2 reset = 1;
    #1;
    check_obs("async_reset_ctrl", dut_obs(), '0);
    check_int("async_reset_status", {busy, halted, illegal_count}, 0);
    #2 reset = 0;
    m_reset();
    #1;
    check_int("ready_after_async", instr_ready, 1);
    push_word(tbl[1].w);
    step();
    check_obs("post_reset_issue", dut_obs(), tbl[1].e);
    wait_idle();

    // Illegal counter saturates at 255.
    apply_reset();
    j = 0; n = 0;
    instr_valid = 1;
    while (j < 262 && n < 600) begin
      instr = 32'h8000_0000 | j;
      step();
      if (last_acc) j++;
      n++;
    end
    instr_valid = 0;
    wait_idle();
    check_int("ill_saturate", illegal_count, 255);

    // Random traffic; an offered word is held until taken.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (!(instr_valid && !last_acc)) begin
        instr_valid = ($urandom_range(0, 3) != 0);
        instr = rand_word();
      end
      step();
    end
    instr_valid = 0;
    wait_idle();
    push_word(32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) step();
    check_int("random_halt", halted, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_issue_ctrl.md
Name: instr_issue_ctrl

Overview:
- Producer side of the datapath control interface: accepts 32-bit instruction words over a valid/ready stream and buffers them in a small FIFO.
- Decodes each word and drives the datapath control bundle: register numbers, alu_control, immediate, imm/lw/sw controls, write_enable, mode.
- Sequences multi-cycle load/store issue and halts on a HALT instruction.
- Sits between instruction fetch and the datapath.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)
MEM_LAT, 2, cycles a LW/SW holds its controls (>=1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction word offered
instr_ready  output  1  block can accept word this cycle
instr  input  32  instruction word
read_reg_num1  output  5  source register 1
read_reg_num2  output  5  source register 2
write_reg  output  5  destination register
alu_control  output  3  ALU operation
immediate  output  16  immediate field
imm_ctrl  output  1  immediate operand select
lw_ctrl  output  1  load control
sw_ctrl  output  1  store control
write_enable  output  1  register-file write strobe
mode  output  1  register-file mode, 1 in write cycle
busy  output  1  FIFO non-empty or issue in progress
halted  output  1  HALT retired
illegal_count  output  8  saturating count of illegal instructions

Behaviour:
- Format:
  - class = instr[31:29]; alu op = instr[28:26].
  - rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], imm = instr[15:0].
  - R-type: instr[2:0] overrides the alu op.
- Classes:
  - 000 R: read1=rs, read2=rt, write_reg=rd, alu_control=instr[2:0].
  - 001 I: imm_ctrl=1, immediate=imm, read2=rt, write_reg=rd, alu_control=op.
  - 010 LW: lw_ctrl=1, read1=rs, read2=rt, alu_control=op.
  - 011 SW: sw_ctrl=1, read1=rs, read2=rt, alu_control=op.
  - 110 NOP: no controls asserted.
  - 111 HALT.
  - 100/101 illegal: handled as NOP; illegal_count +1, saturating at 255.
- Handshake:
  - Transfer when instr_valid && instr_ready.
  - instr_ready = !fifo_full && !halted.
  - A word offered while full is not taken. The source holds it.
- FIFO: circular, log2(FIFO_DEPTH)+1-bit pointers, wrap-around via the MSB compare. Push and pop in the same cycle are both honoured.
- FSM states: IDLE, ISSUE, MEM, HALT.
  - IDLE: all control outputs 0. If FIFO non-empty, pop the head and go to ISSUE.
  - ISSUE, class R/I:
    - Controls held for exactly 1 cycle; write_enable=1, mode=1.
    - Next cycle: if FIFO non-empty, pop and stay in ISSUE; else IDLE.
    - Back-to-back throughput is 1 instruction/cycle.
  - ISSUE, NOP/illegal: 1 cycle, write_enable=0, mode=0, then same as R/I.
  - ISSUE, LW/SW: enter MEM; controls held for MEM_LAT cycles in total.
    - write_enable=1 and mode=1 only in the final cycle, for LW only.
    - SW never asserts write_enable.
  - HALT:
    - Entered on issuing HALT; halted=1; all controls 0.
    - Remaining FIFO entries are discarded (FIFO flushed on entry).
    - Exit only by reset.
- Latency: a word accepted at edge k into an empty, idle block has its controls valid from edge k+1 to edge k+2.
- All control outputs are registered.
- Reset (async, immediate, any state, including mid-MEM):
  - FIFO empty; FSM IDLE.
  - All control outputs 0; halted=0; illegal_count=0; busy=0.
  - instr_ready=1 once reset deasserts.
- busy = (FIFO non-empty) || (state != IDLE && state != HALT).

Test Plan:
- R-type stream: push 0x0022_1802 then 0x0043_2005 back-to-back -> two consecutive issue cycles:
  - cycle 1: read1=1, read2=2, write_reg=3, alu=2, write_enable=1.
  - cycle 2: read1=2, read2=3, write_reg=4, alu=5, write_enable=1.
- I-type: instr=0x2420_10FF (class 001, op 001, rs=1, rt=0, rd=2) -> imm_ctrl=1, immediate=0x10FF, write_reg=2, alu=1 for 1 cycle.
- LW with MEM_LAT=2: class 010, rs=5, rt=6 -> lw_ctrl=1 for 2 cycles; write_enable=1 only in the 2nd.
  - Next queued R-type issues on the following cycle.
- FIFO full: hold instr_valid=1 while a LW occupies MEM with FIFO_DEPTH=4 -> instr_ready falls after 4 accepts; no word lost or duplicated; order preserved.
- Illegal/HALT: push class 100 ×3, then HALT, then an R-type -> illegal_count=3, no write_enable pulses, halted=1, R-type never issued, instr_ready=0.
- Async reset mid-MEM: assert reset during the first MEM cycle -> all controls 0 immediately; FIFO empty; after release, a new R-type issues normally.
